// File: rtl/pipeline_cpu.sv
// 5-stage in-order DLX-subset core (IF/ID/EX/MEM/WB) with internal Harvard memories.
// Branches resolve in EX, full EX/MEM and MEM/WB bypassing, one-cycle load-use stall, TRAP halts.

module pipeline_cpu_imem #(
    parameter int IMEM_WORDS = 4096
) (
    input  logic [29:0] addr_i,
    output logic [31:0] data_o
);
    localparam int AW = $clog2(IMEM_WORDS);
    logic [31:0] mem [0:IMEM_WORDS-1];

    // Asynchronous word read; fetches past the end return a NOP.
    always_comb begin
        if (addr_i < 30'(IMEM_WORDS)) begin
            data_o = mem[addr_i[AW-1:0]];
        end else begin
            data_o = 32'h0000_0000;
        end
    end
endmodule

module pipeline_cpu_ifu #(
    parameter int          IMEM_WORDS = 4096,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hold_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    output logic [31:0] instruction,
    output logic [31:0] pcout
);
    logic [31:0] pc_q;
    logic [31:0] mux2;

    // Next-PC select: taken branch beats a stall/halt hold.
    always_comb begin
        if (redirect_i) begin
            mux2 = target_i;
        end else if (hold_i) begin
            mux2 = pc_q;
        end else begin
            mux2 = pc_q + 32'd4;
        end
    end

    // Program counter register.
    always_ff @(posedge clock) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= mux2;
    end

    assign pcout = pc_q;

    pipeline_cpu_imem #(.IMEM_WORDS(IMEM_WORDS)) IMEM (.addr_i(pc_q[31:2]), .data_o(instruction));
endmodule

module pipeline_cpu_dmem #(
    parameter int DMEM_SIZE = 16384
) (
    input  logic        clock,
    input  logic        we_i,
    input  logic [29:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    localparam int SIZE = DMEM_SIZE;
    localparam int AW   = $clog2(SIZE);
    logic [7:0]    mem [0:SIZE-1];
    logic          in_range_s;
    logic [AW-1:0] ba_s;

    assign in_range_s = (addr_i < 30'(SIZE / 4));
    assign ba_s       = {addr_i[AW-3:0], 2'b00};

    // Big-endian asynchronous word read; out-of-range reads return zero.
    always_comb begin
        if (in_range_s) begin
            rdata_o = {mem[ba_s], mem[ba_s + AW'(1)], mem[ba_s + AW'(2)], mem[ba_s + AW'(3)]};
        end else begin
            rdata_o = 32'h0000_0000;
        end
    end

    // Word write; out-of-range writes are dropped.
    always_ff @(posedge clock) begin
        if (we_i && in_range_s) begin
            mem[ba_s]          <= wdata_i[31:24];
            mem[ba_s + AW'(1)] <= wdata_i[23:16];
            mem[ba_s + AW'(2)] <= wdata_i[15:8];
            mem[ba_s + AW'(3)] <= wdata_i[7:0];
        end
    end
endmodule

module pipeline_cpu #(
    parameter int          IMEM_WORDS = 4096,
    parameter int          DMEM_SIZE  = 16384,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic clock,
    input logic reset
);
    logic [31:0] instruction, if_pc_s;
    logic [31:0] ifid_ir_q, ifid_pc_q, ifid_ir_d, ifid_pc_d;
    logic [31:0] idex_ir_q, idex_pc_q, idex_a_q, idex_b_q;
    logic [31:0] idex_ir_d, idex_pc_d, idex_a_d, idex_b_d;
    logic        exmem_we_q, exmem_ld_q, exmem_st_q;
    logic [4:0]  exmem_rd_q;
    logic [31:0] exmem_res_q, exmem_sd_q;
    logic        memwb_we_q;
    logic [4:0]  memwb_rd_q;
    logic [31:0] memwb_val_q;
    logic        halt_q, halt_d;
    logic [31:0] rf_q [0:31];

    logic [5:0]  id_op_s;
    logic [4:0]  id_rs1_s, id_rs2_s;
    logic [31:0] id_a_s, id_b_s;
    logic        id_use1_s, id_use2_s, load_use_s, pc_hold_s, ex_flush_s;
    logic [5:0]  ex_op_s;
    logic [4:0]  ex_rs1_s, ex_rs2_s, ex_rd_s;
    logic [31:0] ex_a_s, ex_b_s, ex_res_s, ex_tgt_s, imm_s_s, imm_z_s;
    logic        ex_we_s, ex_ld_s, ex_st_s, ex_taken_s;
    logic [31:0] dm_rdata_s, mem_val_s;

    pipeline_cpu_ifu #(.IMEM_WORDS(IMEM_WORDS), .RESET_PC(RESET_PC)) IFU (
        .clock(clock), .reset(reset), .hold_i(pc_hold_s), .redirect_i(ex_flush_s),
        .target_i(ex_tgt_s), .instruction(instruction), .pcout(if_pc_s)
    );

    assign id_op_s  = ifid_ir_q[31:26];
    assign id_rs1_s = ifid_ir_q[25:21];
    assign id_rs2_s = ifid_ir_q[20:16];

    // Register read with write-back bypass (WB writes in the first half of the cycle).
    always_comb begin
        if (id_rs1_s == 5'd0)                               id_a_s = 32'h0;
        else if (memwb_we_q && memwb_rd_q == id_rs1_s)      id_a_s = memwb_val_q;
        else                                                id_a_s = rf_q[id_rs1_s];
        if (id_rs2_s == 5'd0)                               id_b_s = 32'h0;
        else if (memwb_we_q && memwb_rd_q == id_rs2_s)      id_b_s = memwb_val_q;
        else                                                id_b_s = rf_q[id_rs2_s];
        case (id_op_s)
            6'h02, 6'h03, 6'h0F, 6'h11: begin id_use1_s = 1'b0; id_use2_s = 1'b0; end
            6'h00, 6'h2B:               begin id_use1_s = 1'b1; id_use2_s = 1'b1; end
            default:                    begin id_use1_s = 1'b1; id_use2_s = 1'b0; end
        endcase
    end

    assign ex_op_s  = idex_ir_q[31:26];
    assign ex_rs1_s = idex_ir_q[25:21];
    assign ex_rs2_s = idex_ir_q[20:16];
    assign imm_s_s  = {{16{idex_ir_q[15]}}, idex_ir_q[15:0]};
    assign imm_z_s  = {16'h0000, idex_ir_q[15:0]};

    // Operand bypass: EX/MEM (non-load) first, then MEM/WB.
    always_comb begin
        if (exmem_we_q && !exmem_ld_q && exmem_rd_q != 5'd0 && exmem_rd_q == ex_rs1_s) ex_a_s = exmem_res_q;
        else if (memwb_we_q && memwb_rd_q != 5'd0 && memwb_rd_q == ex_rs1_s)            ex_a_s = memwb_val_q;
        else                                                                             ex_a_s = idex_a_q;
        if (exmem_we_q && !exmem_ld_q && exmem_rd_q != 5'd0 && exmem_rd_q == ex_rs2_s) ex_b_s = exmem_res_q;
        else if (memwb_we_q && memwb_rd_q != 5'd0 && memwb_rd_q == ex_rs2_s)            ex_b_s = memwb_val_q;
        else                                                                             ex_b_s = idex_b_q;
    end

    // Execute: ALU, address generation, branch resolution.
    always_comb begin
        ex_res_s = 32'h0; ex_we_s = 1'b0; ex_rd_s = idex_ir_q[20:16];
        ex_ld_s = 1'b0; ex_st_s = 1'b0; ex_taken_s = 1'b0;
        ex_tgt_s = idex_pc_q + 32'd4 + imm_s_s;
        case (ex_op_s)
            6'h00: begin
                ex_rd_s = idex_ir_q[15:11];
                ex_we_s = 1'b1;
                case (idex_ir_q[5:0])
                    6'h20, 6'h21: ex_res_s = ex_a_s + ex_b_s;
                    6'h22, 6'h23: ex_res_s = ex_a_s - ex_b_s;
                    6'h24:        ex_res_s = ex_a_s & ex_b_s;
                    6'h25:        ex_res_s = ex_a_s | ex_b_s;
                    6'h26:        ex_res_s = ex_a_s ^ ex_b_s;
                    6'h04:        ex_res_s = ex_a_s << ex_b_s[4:0];
                    6'h06:        ex_res_s = ex_a_s >> ex_b_s[4:0];
                    6'h07:        ex_res_s = 32'($signed(ex_a_s) >>> ex_b_s[4:0]);
                    6'h2A:        ex_res_s = {31'h0, $signed(ex_a_s) < $signed(ex_b_s)};
                    6'h2B:        ex_res_s = {31'h0, ex_a_s < ex_b_s};
                    default:      ex_we_s  = 1'b0;
                endcase
            end
            6'h08: begin ex_we_s = 1'b1; ex_res_s = ex_a_s + imm_s_s; end
            6'h09: begin ex_we_s = 1'b1; ex_res_s = ex_a_s + imm_z_s; end
            6'h0A: begin ex_we_s = 1'b1; ex_res_s = ex_a_s - imm_s_s; end
            6'h0C: begin ex_we_s = 1'b1; ex_res_s = ex_a_s & imm_z_s; end
            6'h0D: begin ex_we_s = 1'b1; ex_res_s = ex_a_s | imm_z_s; end
            6'h0E: begin ex_we_s = 1'b1; ex_res_s = ex_a_s ^ imm_z_s; end
            6'h0F: begin ex_we_s = 1'b1; ex_res_s = {idex_ir_q[15:0], 16'h0000}; end
            6'h1A: begin ex_we_s = 1'b1; ex_res_s = {31'h0, $signed(ex_a_s) < $signed(imm_s_s)}; end
            6'h23: begin ex_we_s = 1'b1; ex_ld_s = 1'b1; ex_res_s = ex_a_s + imm_s_s; end
            6'h2B: begin ex_st_s = 1'b1; ex_res_s = ex_a_s + imm_s_s; end
            6'h04: ex_taken_s = (ex_a_s == 32'h0);
            6'h05: ex_taken_s = (ex_a_s != 32'h0);
            6'h02, 6'h03: begin
                ex_taken_s = 1'b1;
                ex_tgt_s   = idex_pc_q + 32'd4 + {{6{idex_ir_q[25]}}, idex_ir_q[25:0]};
                ex_we_s    = (ex_op_s == 6'h03);
                ex_rd_s    = 5'd31;
                ex_res_s   = idex_pc_q + 32'd4;
            end
            default: ex_we_s = 1'b0;
        endcase
    end

    assign ex_flush_s = ex_taken_s && !halt_q;
    assign load_use_s = ex_ld_s && (ex_rd_s != 5'd0) &&
                        ((id_use1_s && id_rs1_s == ex_rd_s) || (id_use2_s && id_rs2_s == ex_rd_s));

    // Hazard control: flush beats halt/TRAP, which beats the load-use stall.
    always_comb begin
        ifid_ir_d = instruction; ifid_pc_d = if_pc_s;
        idex_ir_d = ifid_ir_q;   idex_pc_d = ifid_pc_q; idex_a_d = id_a_s; idex_b_d = id_b_s;
        halt_d = halt_q; pc_hold_s = 1'b0;
        if (ex_flush_s) begin
            ifid_ir_d = 32'h0; idex_ir_d = 32'h0;
        end else if (halt_q || id_op_s == 6'h11) begin
            ifid_ir_d = 32'h0; idex_ir_d = 32'h0; pc_hold_s = 1'b1; halt_d = 1'b1;
        end else if (load_use_s) begin
            ifid_ir_d = ifid_ir_q; ifid_pc_d = ifid_pc_q; idex_ir_d = 32'h0; pc_hold_s = 1'b1;
        end else begin
            halt_d = halt_q;
        end
    end

    pipeline_cpu_dmem #(.DMEM_SIZE(DMEM_SIZE)) DMEM (
        .clock(clock), .we_i(exmem_st_q && !reset), .addr_i(exmem_res_q[31:2]),
        .wdata_i(exmem_sd_q), .rdata_o(dm_rdata_s)
    );
    assign mem_val_s = exmem_ld_q ? dm_rdata_s : exmem_res_q;

    // Pipeline registers; reset fills every stage with a bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            ifid_ir_q <= 32'h0; ifid_pc_q <= 32'h0;
            idex_ir_q <= 32'h0; idex_pc_q <= 32'h0; idex_a_q <= 32'h0; idex_b_q <= 32'h0;
            exmem_we_q <= 1'b0; exmem_ld_q <= 1'b0; exmem_st_q <= 1'b0; exmem_rd_q <= 5'd0;
            exmem_res_q <= 32'h0; exmem_sd_q <= 32'h0;
            memwb_we_q <= 1'b0; memwb_rd_q <= 5'd0; memwb_val_q <= 32'h0;
            halt_q <= 1'b0;
        end else begin
            ifid_ir_q <= ifid_ir_d; ifid_pc_q <= ifid_pc_d;
            idex_ir_q <= idex_ir_d; idex_pc_q <= idex_pc_d; idex_a_q <= idex_a_d; idex_b_q <= idex_b_d;
            exmem_we_q <= ex_we_s; exmem_ld_q <= ex_ld_s; exmem_st_q <= ex_st_s; exmem_rd_q <= ex_rd_s;
            exmem_res_q <= ex_res_s; exmem_sd_q <= ex_b_s;
            memwb_we_q <= exmem_we_q; memwb_rd_q <= exmem_rd_q; memwb_val_q <= mem_val_s;
            halt_q <= halt_d;
        end
    end

    // Register file write port; r0 is never written.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
        end else if (memwb_we_q && memwb_rd_q != 5'd0) begin
            rf_q[memwb_rd_q] <= memwb_val_q;
        end
    end
endmodule

// File: tb/tb_pipeline_cpu.sv
// Directed bench for pipeline_cpu: table of single-op programs plus hand-written
// sequences for load-use, loops, JAL, forwarding, out-of-range memory and mid-run reset.
module tb_pipeline_cpu;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pipeline_cpu dut (.clock(clock), .reset(reset));

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] insn;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] prog[$];
    localparam logic [31:0] TRAP = 32'h4400_0300;

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {6'h00, rs1, rs2, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rd_word(input int a);
        return {dut.DMEM.mem[a], dut.DMEM.mem[a+1], dut.DMEM.mem[a+2], dut.DMEM.mem[a+3]};
    endfunction

    task automatic wr_word(input int a, input logic [31:0] v);
        dut.DMEM.mem[a]   = v[31:24];
        dut.DMEM.mem[a+1] = v[23:16];
        dut.DMEM.mem[a+2] = v[15:8];
        dut.DMEM.mem[a+3] = v[7:0];
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 64; i++) dut.IFU.IMEM.mem[i] = 32'h0;
        for (int i = 0; i < prog.size(); i++) dut.IFU.IMEM.mem[i] = prog[i];
    endtask

    task automatic start();
        @(negedge clock); reset = 1'b1;
        @(negedge clock); @(negedge clock); reset = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        for (int i = 0; i < 3000 && !dut.halt_q; i++) @(negedge clock);
        check({"halt ", name}, {31'h0, dut.halt_q}, 32'h1);
        repeat (6) @(negedge clock);
    endtask

    task automatic load_loop();
        for (int i = 0; i < 10; i++) wr_word(32'h2000 + 4*i, (i+1)*(i+1));
        wr_word(32'h2028, 32'hDEAD_BEEF);
        wr_word(32'h202C, 32'hDEAD_BEEF);
        prog = '{enc_i(6'h08, 1, 0, 16'd10), enc_i(6'h08, 2, 0, 16'h2000), enc_i(6'h08, 3, 0, 16'h0),
                 enc_i(6'h23, 4, 2, 16'h0), enc_r(6'h20, 3, 3, 4), enc_i(6'h08, 2, 2, 16'd4),
                 enc_i(6'h0A, 1, 1, 16'd1), enc_i(6'h05, 0, 1, 16'hFFEC), enc_i(6'h08, 6, 6, 16'd1),
                 enc_i(6'h2B, 3, 0, 16'h2028), enc_i(6'h2B, 6, 0, 16'h202C), TRAP};
        load_prog();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) dut.IFU.IMEM.mem[i] = 32'h0;
        for (int i = 32'h2000; i < 32'h2100; i++) dut.DMEM.mem[i] = 8'h00;

        vecs.push_back('{"add",        32'd5,        32'd7,        enc_r(6'h20, 3, 1, 2), 32'd12});
        vecs.push_back('{"sub",        32'd5,        32'd7,        enc_r(6'h22, 3, 1, 2), 32'hFFFF_FFFE});
        vecs.push_back('{"addu_wrap",  32'hFFFF_FFFF, 32'd1,       enc_r(6'h21, 3, 1, 2), 32'h0});
        vecs.push_back('{"subu",       32'd0,        32'd1,        enc_r(6'h23, 3, 1, 2), 32'hFFFF_FFFF});
        vecs.push_back('{"and",        32'hF0F0_F0F0, 32'hFF00_FF00, enc_r(6'h24, 3, 1, 2), 32'hF000_F000});
        vecs.push_back('{"or",         32'hF0F0_F0F0, 32'hFF00_FF00, enc_r(6'h25, 3, 1, 2), 32'hFFF0_FFF0});
        vecs.push_back('{"xor",        32'hF0F0_F0F0, 32'hFF00_FF00, enc_r(6'h26, 3, 1, 2), 32'h0FF0_0FF0});
        vecs.push_back('{"sll",        32'd1,        32'd31,       enc_r(6'h04, 3, 1, 2), 32'h8000_0000});
        vecs.push_back('{"sll_mod32",  32'd1,        32'd33,       enc_r(6'h04, 3, 1, 2), 32'h2});
        vecs.push_back('{"srl",        32'h8000_0000, 32'd4,       enc_r(6'h06, 3, 1, 2), 32'h0800_0000});
        vecs.push_back('{"sra",        32'h8000_0000, 32'd4,       enc_r(6'h07, 3, 1, 2), 32'hF800_0000});
        vecs.push_back('{"slt",        32'hFFFF_FFFF, 32'd1,       enc_r(6'h2A, 3, 1, 2), 32'h1});
        vecs.push_back('{"sltu",       32'hFFFF_FFFF, 32'd1,       enc_r(6'h2B, 3, 1, 2), 32'h0});
        vecs.push_back('{"addi_neg",   32'd1,        32'd0,        enc_i(6'h08, 3, 1, 16'hFFFF), 32'h0});
        vecs.push_back('{"addui_zext", 32'd1,        32'd0,        enc_i(6'h09, 3, 1, 16'hFFFF), 32'h0001_0000});
        vecs.push_back('{"subi",       32'd0,        32'd0,        enc_i(6'h0A, 3, 1, 16'h0001), 32'hFFFF_FFFF});
        vecs.push_back('{"andi",       32'hFFFF_FFFF, 32'd0,       enc_i(6'h0C, 3, 1, 16'h8001), 32'h0000_8001});
        vecs.push_back('{"ori",        32'h1234_0000, 32'd0,       enc_i(6'h0D, 3, 1, 16'h5678), 32'h1234_5678});
        vecs.push_back('{"xori",       32'h1234_5678, 32'd0,       enc_i(6'h0E, 3, 1, 16'h00FF), 32'h1234_5687});
        vecs.push_back('{"lhi",        32'd0,        32'd0,        enc_i(6'h0F, 3, 0, 16'hABCD), 32'hABCD_0000});
        vecs.push_back('{"slti",       32'hFFFF_FFFE, 32'd0,       enc_i(6'h1A, 3, 1, 16'hFFFF), 32'h1});
        vecs.push_back('{"unknown_op", 32'd5,        32'd7,        {6'h3F, 5'd1, 5'd3, 16'h1234}, 32'h0});

        // Reset state
        @(negedge clock); @(negedge clock);
        check("reset pc", dut.IFU.pcout, 32'h0);
        check("reset halt", {31'h0, dut.halt_q}, 32'h0);

        // Basic program with byte-level big-endian check
        wr_word(32'h2000, 32'hDEAD_BEEF);
        prog = '{enc_i(6'h08, 1, 0, 16'd5), enc_i(6'h08, 2, 0, 16'd7), enc_r(6'h20, 3, 1, 2),
                 enc_i(6'h2B, 3, 0, 16'h2000), TRAP};
        load_prog(); start(); wait_halt("basic");
        check("basic byte0", {24'h0, dut.DMEM.mem[32'h2000]}, 32'h00);
        check("basic byte1", {24'h0, dut.DMEM.mem[32'h2001]}, 32'h00);
        check("basic byte2", {24'h0, dut.DMEM.mem[32'h2002]}, 32'h00);
        check("basic byte3", {24'h0, dut.DMEM.mem[32'h2003]}, 32'h0C);

        // Table of single ALU operations on 32-bit operands built with LHI/ORI
        foreach (vecs[k]) begin
            wr_word(32'h2000, 32'hDEAD_BEEF);
            prog = '{enc_i(6'h0F, 1, 0, vecs[k].a[31:16]), enc_i(6'h0D, 1, 1, vecs[k].a[15:0]),
                     enc_i(6'h0F, 2, 0, vecs[k].b[31:16]), enc_i(6'h0D, 2, 2, vecs[k].b[15:0]),
                     vecs[k].insn, enc_i(6'h2B, 3, 0, 16'h2000), TRAP};
            load_prog(); start(); wait_halt(vecs[k].name);
            check(vecs[k].name, rd_word(32'h2000), vecs[k].exp);
        end

        // Load-use
        wr_word(32'h2000, 32'hFFFF_FFFF);
        wr_word(32'h2004, 32'h0);
        prog = '{enc_i(6'h23, 1, 0, 16'h2000), enc_r(6'h21, 2, 1, 1), enc_i(6'h2B, 2, 0, 16'h2004), TRAP};
        load_prog(); start(); wait_halt("load_use");
        check("load_use", rd_word(32'h2004), 32'hFFFF_FFFE);

        // Back-to-back forwarding including store data
        prog = '{enc_i(6'h08, 1, 0, 16'h0123), enc_r(6'h22, 2, 0, 1), enc_r(6'h26, 3, 2, 1),
                 enc_i(6'h2B, 3, 0, 16'h2000), enc_i(6'h2B, 2, 0, 16'h2004), TRAP};
        load_prog(); start(); wait_halt("fwd");
        check("fwd xor", rd_word(32'h2000), 32'hFFFF_FFFE);
        check("fwd sub", rd_word(32'h2004), 32'hFFFF_FEDD);

        // JAL to subroutine, J back
        wr_word(32'h2000, 32'hDEAD_BEEF);
        wr_word(32'h2004, 32'hDEAD_BEEF);
        prog = '{enc_i(6'h08, 1, 0, 16'd3), {6'h03, 26'd12}, enc_i(6'h08, 1, 1, 16'd1),
                 enc_i(6'h2B, 1, 0, 16'h2004), TRAP, enc_i(6'h2B, 31, 0, 16'h2000), {6'h02, 26'h3FF_FFF0}};
        load_prog(); start(); wait_halt("jal");
        check("jal link", rd_word(32'h2000), 32'h0000_0008);
        check("jal skip", rd_word(32'h2004), 32'h0000_0003);

        // Out-of-range store dropped and load returns zero
        wr_word(32'h2000, 32'hDEAD_BEEF);
        prog = '{enc_i(6'h08, 1, 0, 16'h005A), enc_i(6'h2B, 1, 0, 16'h4000), enc_i(6'h23, 2, 0, 16'h4000),
                 enc_i(6'h2B, 2, 0, 16'h2000), TRAP};
        load_prog(); start(); wait_halt("oor");
        check("oor load", rd_word(32'h2000), 32'h0);

        // Summing loop with taken branches
        load_loop(); start(); wait_halt("loop");
        check("loop sum", rd_word(32'h2028), 32'd385);
        check("loop wrongpath", rd_word(32'h202C), 32'd1);

        // Reset mid-run: restart at PC 0 and rerun to the same result
        load_loop(); start();
        repeat (40) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset pc", dut.IFU.pcout, 32'h0);
        reset = 1'b0;
        wait_halt("midreset");
        check("midreset sum", rd_word(32'h2028), 32'd385);
        check("midreset wrongpath", rd_word(32'h202C), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
